pattern_scan_ctrl: RTL
======================

# pattern_scan_ctrl

Sequencer that streams parallel words bit-serially through a programmable serial pattern detector and schedules complete scan jobs. A host loads a PAT_W-bit target pattern, starts a job of N words, and supplies words over a valid/ready handshake. The block serialises each word MSB-first, detects overlapping pattern occurrences (Mealy style, same-cycle flag) and reports a saturating match count with a done pulse. It sits between a word-wide producer and the serial detection path and owns all sequencing of that path.

## Interface
- WORD_W, 8, width of an input word / bits serialised per word
- PAT_W, 4, pattern length in bits (2..WORD_W)
- CNT_W, 8, match counter width
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- cfg_pattern  input  PAT_W  target pattern, first-received bit in MSB
- cfg_load  input  1  latch cfg_pattern (honoured in IDLE only)
- start  input  1  begin job (honoured in IDLE only)
- nwords  input  8  words in job, sampled with start
- in_data  input  WORD_W  word to scan
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a word this cycle
- bit_out  output  1  current serial bit
- bit_valid  output  1  bit_out is live (SHIFT state)
- match  output  1  pattern completes on this cycle's bit
- match_count  output  CNT_W  matches in current/last job, saturating
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at job end

## Operation
- Reset (RST_N low, async): state IDLE; pattern reg 0; history, bit index, word counter, bits_seen, match_count cleared; in_ready, bit_valid, bit_out, match, busy, done all 0.
- IDLE: cfg_load=1 latches cfg_pattern. start=1 captures nwords, clears history, bits_seen and match_count; next state WAIT, or DONE if nwords==0. start and cfg_load together: pattern latched and job started with the new pattern. start/cfg_load outside IDLE ignored.
- WAIT: in_ready=1. On in_valid&in_ready word captured into shift reg; next state SHIFT. in_valid low stalls indefinitely; history preserved.
- SHIFT: exactly WORD_W cycles, bit_valid=1, bit_out = shift reg MSB, shift left each cycle. History reg (PAT_W-1 bits) shifts in bit_out. After last bit: remaining words>0 -> WAIT, else DONE.
- match = bit_valid & (bits_seen >= PAT_W-1) & ({history, bit_out} == pattern). Combinational; bits_seen saturates at PAT_W-1. Overlaps counted; history spans word boundaries within a job.
- match_count increments on match, saturates at 2^CNT_W-1, held after job until next accepted start.
- DONE: done=1 for one cycle, busy=1; next IDLE.

## Timing
- start accepted at edge t: busy=1 and in_ready=1 from t+1.
- Handshake at edge h: bit_valid=1 with word MSB from h+1 for WORD_W cycles; in_ready low during SHIFT.
- Next word earliest handshake one cycle after last bit (WAIT cycle) -> WORD_W+1 cycles/word minimum.
- done high the cycle after last bit of last word; busy falls the cycle after done. nwords==0: done at t+1.
- match_count reflects a match one edge after the match cycle; final count valid when done is high.
- Reset asserted mid-job aborts immediately: no done pulse, count cleared, ready for new config after release.

## Test plan
- Load 4'b1101, start nwords=1, word 8'b1101_1010 -> match on bits 4 and 7 (overlap), done with match_count=2.
- Cross-word: 4'b1101, nwords=2, words 8'h06, 8'h80 -> single match on first bit of word 2, count=1.
- nwords=0 -> done pulse one cycle after start, count 0, in_ready never asserted.
- Stall/ignore: in_valid low 10 cycles in WAIT -> no bits emitted; start and cfg_load pulsed during SHIFT -> no effect on job or pattern.
- Saturation with CNT_W=4: pattern 4'b0000, nwords=3, all words 8'h00 -> 5+8+8 matches, match_count=15.
- RST_N low during SHIFT of word 2 -> all outputs 0 asynchronously; new job afterwards counts from 0 with pattern reg reloaded.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial scan sequencer with a programmable overlapping Mealy pattern detector.
// One word per WORD_W+1 cycles minimum; in_ready only in WAIT, so stalled words hold history.
module pattern_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_load,
  input  logic              start,
  input  logic [7:0]        nwords,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W  = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int SEEN_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t            state_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [WORD_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        words_q;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, bit_valid_q, busy_q, done_q;
  logic [PAT_W-1:0]  window;

  // The detector window is the last PAT_W-1 bits of the job plus the live bit.
  always_comb begin
    window = {hist_q, shift_q[WORD_W-1]};
    hist_d = window[PAT_W-2:0];
    match  = bit_valid_q && (seen_q == SEEN_MAX) && (window == pat_q);
    seen_d = (seen_q != SEEN_MAX) ? seen_q + 1'b1 : seen_q;
    cnt_d  = (match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      hist_q      <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      words_q     <= '0;
      seen_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_load) pat_q <= cfg_pattern;
          if (start) begin
            words_q <= nwords;
            hist_q  <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (nwords == 8'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (in_valid && in_ready_q) begin
            shift_q     <= in_data;
            words_q     <= words_q - 8'd1;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b1;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Zero-fill keeps bit_out low once the word has drained.
          shift_q <= {shift_q[WORD_W-2:0], 1'b0};
          hist_q  <= hist_d;
          seen_q  <= seen_d;
          cnt_q   <= cnt_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            bit_valid_q <= 1'b0;
            if (words_q != 8'd0) begin
              in_ready_q <= 1'b1;
              state_q    <= S_WAIT;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign bit_out     = shift_q[WORD_W-1];
  assign bit_valid   = bit_valid_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
